shift_seq_ctrl: RTL and testbench

Command-driven sequencer for the team's WIDTH-bit universal shift register. It accepts one operation per valid/ready handshake: parallel load, shift left, shift right, or rotate left by a count. It generates the register's `sel`/`pi`/`si` controls cycle by cycle and reports completion with a one-cycle done pulse plus a registered copy of the resulting word. It sits between a command producer (CPU register interface or test sequencer) and the shift-register datapath, and shares that datapath's clock and reset.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_seq_ctrl_if.sv | 23 ++
 rtl/shift_cnt.sv | 26 ++
 rtl/shift_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared op-code, register-mode and state definitions for the shift sequencer.
// Pure declarations: no timing or flow control of its own.
package shift_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command channel into the shift sequencer: one operation per valid/ready handshake.
// The producer must hold cmd_valid while cmd_ready is low.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/shift_cnt.sv
// Loadable down-counter; last flags a count of one so the caller can stop on time.
// Load has priority over decrement; no backpressure, updates every enabled cycle.
module shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign last = (count_q == CNT_W'(1));
endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences load/shift/rotate commands onto a universal shift register; done pulses N+2 cycles after accept (3 for LOAD).
// Accepts only in IDLE (cmd_ready), so a new command can land in the done cycle.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  cmd,
    input  logic [WIDTH-1:0] reg_po,
    output logic [1:0]       reg_sel,
    output logic [WIDTH-1:0] reg_pi,
    output logic             reg_si,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             fill_q;
    logic             accept;
    logic             cnt_dec;
    logic             cnt_last;

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = ~cmd.cmd_ready;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;

    shift_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (cnt_dec),
        .load_val (cmd.cmd_count),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd.cmd_op;
                data_q <= cmd.cmd_data;
                fill_q <= cmd.cmd_fill;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        reg_sel = SEL_HOLD;
        reg_pi  = '0;
        reg_si  = 1'b0;
        cnt_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd.cmd_op == OP_LOAD)
                        state_d = ST_LOAD;
                    else if (cmd.cmd_count == '0)
                        state_d = ST_DONE;
                    else
                        state_d = ST_SHIFT;
                end
            end
            ST_LOAD: begin
                reg_sel = SEL_LOAD;
                reg_pi  = data_q;
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                case (op_q)
                    OP_SHL: begin
                        reg_sel = SEL_LEFT;
                        reg_si  = fill_q;
                    end
                    OP_SHR: begin
                        reg_sel = SEL_RIGHT;
                        reg_si  = fill_q;
                    end
                    OP_ROTL: begin
                        // Rotation feeds the live MSB back in, so it tracks each shift step.
                        reg_sel = SEL_LEFT;
                        reg_si  = reg_po[WIDTH-1];
                    end
                    default: begin
                        reg_sel = SEL_HOLD;
                    end
                endcase
                if (cnt_last)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= (state_q == ST_DONE);
            if (state_q == ST_DONE)
                result <= reg_po;
        end
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: sequencer driving a behavioural 5-bit universal shift register.
module tb_shift_seq_ctrl;
    localparam int WIDTH = 5;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] reg_po;
    logic [1:0]       reg_sel;
    logic [WIDTH-1:0] reg_pi;
    logic             reg_si;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] sr;

    int n_checks = 0;
    int n_errors = 0;

    shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd ();

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd),
        .reg_po  (reg_po),
        .reg_sel (reg_sel),
        .reg_pi  (reg_pi),
        .reg_si  (reg_si),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Universal shift register sharing the controller's clock and reset.
    always @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            case (reg_sel)
                2'b01:   sr <= {sr[WIDTH-2:0], reg_si};
                2'b10:   sr <= {reg_si, sr[WIDTH-1:1]};
                2'b11:   sr <= reg_pi;
                default: sr <= sr;
            endcase
        end
    end
    assign reg_po = sr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command in the current cycle and returns in its done cycle.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] cnt,
                           input logic [4:0] data, input logic fill, input logic [4:0] exp_res,
                           input int exp_act, input logic [1:0] exp_sel, input int exp_done,
                           input bit si_zero);
        int act;
        int dcyc;
        act  = 0;
        dcyc = -1;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_count = cnt;
        cmd.cmd_data  = data;
        cmd.cmd_fill  = fill;
        chk({tag, "_ready"}, cmd.cmd_ready, 1);
        step();
        cmd.cmd_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        for (int k = 1; k <= 20; k++) begin
            if (reg_sel != 2'b00) begin
                act++;
                chk({tag, "_sel"}, reg_sel, exp_sel);
                if (op == 2'b00) chk({tag, "_pi"}, reg_pi, data);
                if (si_zero) chk({tag, "_si"}, reg_si, 0);
            end
            if (done) begin
                dcyc = k;
                break;
            end
            step();
        end
        chk({tag, "_done_cycle"}, dcyc, exp_done);
        chk({tag, "_active"}, act, exp_act);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_ready_in_done"}, cmd.cmd_ready, 1);
    endtask

    initial begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_count = '0;
        cmd.cmd_data  = '0;
        cmd.cmd_fill  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready",  cmd.cmd_ready, 1);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_result", result, 5'b00000);
        chk("rst_sel",    reg_sel, 2'b00);

        run_cmd("load",  2'b00, 3'd0, 5'b10110, 1'b0, 5'b10110, 1, 2'b11, 3, 1'b0);
        run_cmd("shl3",  2'b01, 3'd3, 5'b00000, 1'b1, 5'b10111, 3, 2'b01, 5, 1'b0);
        run_cmd("rotl2", 2'b11, 3'd2, 5'b00000, 1'b0, 5'b11110, 2, 2'b01, 4, 1'b0);
        run_cmd("shr2",  2'b10, 3'd2, 5'b00000, 1'b0, 5'b00111, 2, 2'b10, 4, 1'b1);
        run_cmd("shr0",  2'b10, 3'd0, 5'b00000, 1'b1, 5'b00111, 0, 2'b00, 2, 1'b0);
        step();
        chk("shr0_done_clears", done, 0);
        chk("shr0_result_holds", result, 5'b00111);

        // SHL 7 interrupted by reset in cycle 3.
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = 2'b01;
        cmd.cmd_count = 3'd7;
        cmd.cmd_fill  = 1'b1;
        step();
        cmd.cmd_valid = 1'b0;
        step();
        step();
        chk("abort_sel_c3", reg_sel, 2'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", cmd.cmd_ready, 1);
        chk("abort_busy",  busy, 0);
        chk("abort_done",  done, 0);
        chk("abort_sel",   reg_sel, 2'b00);
        step();
        chk("abort_no_done", done, 0);
        chk("abort_result",  result, 5'b00000);

        // Two LOADs with cmd_valid held high throughout.
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_data  = 5'b01010;
        step();
        cmd.cmd_data  = 5'b11001;
        chk("b2b_c1_sel", reg_sel, 2'b11);
        chk("b2b_c1_pi",  reg_pi, 5'b01010);
        chk("b2b_c1_ready", cmd.cmd_ready, 0);
        step();
        chk("b2b_c2_sel", reg_sel, 2'b00);
        step();
        chk("b2b_c3_done",   done, 1);
        chk("b2b_c3_result", result, 5'b01010);
        chk("b2b_c3_ready",  cmd.cmd_ready, 1);
        step();
        cmd.cmd_valid = 1'b0;
        chk("b2b_c4_done", done, 0);
        chk("b2b_c4_sel",  reg_sel, 2'b11);
        chk("b2b_c4_pi",   reg_pi, 5'b11001);
        step();
        step();
        chk("b2b_c6_done",   done, 1);
        chk("b2b_c6_result", result, 5'b11001);
        step();
        chk("b2b_c7_idle", reg_sel, 2'b00);
        chk("b2b_c7_done", done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
